// File: rtl/instr_pkg.sv
// Shared opcode constants, ALU encodings, decoded-entry layout and the decode
// function for the buffered accumulator-CPU instruction decoder.
package instr_pkg;

  localparam int OPC_W      = 4;
  // Widest register address the decoded-entry layout can carry; callers narrow it.
  localparam int MAX_ADDR_W = 4;
  localparam int MAX_SEL_W  = 2**MAX_ADDR_W - 1;

  localparam logic [OPC_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0010;
  localparam logic [OPC_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OPC_W-1:0] OP_NOT = 4'b0101;
  localparam logic [OPC_W-1:0] OP_LD  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_ST  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_NOP = 4'b1111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_LD  = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic                  acc_ce;
    alu_op_e               alu_op;
    logic [MAX_ADDR_W-1:0] rf_a;
    logic [MAX_SEL_W-1:0]  rf_sel;
  } decoded_t;

  // addr_w selects the live address width so the all-ones RZ address is found correctly.
  function automatic decoded_t decode_instr(input logic [OPC_W-1:0]      opcode,
                                            input logic [MAX_ADDR_W-1:0] adr,
                                            input int unsigned           addr_w);
    decoded_t              d;
    logic [MAX_ADDR_W-1:0] rz;
    d  = '0;
    rz = MAX_ADDR_W'((1 << addr_w) - 1);
    if (opcode[2:0] != 3'b111) begin
      d.acc_ce = 1'b1;
      d.alu_op = alu_op_e'(opcode[2:0]);
      d.rf_a   = adr;
    end else if (opcode == OP_ST && adr != rz) begin
      d.rf_sel = MAX_SEL_W'(1) << adr;
    end
    return d;
  endfunction

endpackage

// File: rtl/instr_decode_pipe_if.sv
// Fetch-side and execute-side signals of instr_decode_pipe.
// DECODE_STATS_EN adds clr_stats and the per-class counters.
interface instr_decode_pipe_if #(parameter int ADDR_W = 2);
  // Both sides: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends combinationally on ready of the same side.
  logic [3+ADDR_W:0]     data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic                  acc_ce;
  logic [2:0]            alu_op;
  logic [ADDR_W-1:0]     rf_a;
  logic [2**ADDR_W-2:0]  rf_sel;
`ifdef DECODE_STATS_EN
  logic                  clr_stats;
  logic [15:0]           cnt_alu;
  logic [15:0]           cnt_st;
  logic [15:0]           cnt_nop;
`endif

  modport master (
    output data, in_valid, flush, out_ready,
`ifdef DECODE_STATS_EN
    output clr_stats,
    input  cnt_alu, cnt_st, cnt_nop,
`endif
    input  in_ready, out_valid, acc_ce, alu_op, rf_a, rf_sel
  );

  modport slave (
    input  data, in_valid, flush, out_ready,
`ifdef DECODE_STATS_EN
    input  clr_stats,
    output cnt_alu, cnt_st, cnt_nop,
`endif
    output in_ready, out_valid, acc_ce, alu_op, rf_a, rf_sel
  );

endinterface

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO with synchronous flush and asynchronous active-low reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// Buffered instruction decoder: decode at push, NOP squash, FIFO, valid-gated controls.
// DECODE_STATS_EN adds saturating per-class accept counters.
module instr_decode_pipe
  import instr_pkg::*;
#(
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_decode_pipe_if.slave  bus
);

  localparam int N_SEL = 2**ADDR_W - 1;
  localparam int EW    = 1 + 3 + ADDR_W + N_SEL;

  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] adr;
  decoded_t          dec;
  logic              is_nop;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [EW-1:0]     din;
  logic [EW-1:0]     dout;

  assign opcode = bus.data[ADDR_W+3 -: 4];
  assign adr    = bus.data[ADDR_W-1:0];
  assign is_nop = (opcode == OP_NOP);

  always_comb dec = decode_instr(opcode, MAX_ADDR_W'(adr), ADDR_W);

  assign din = {dec.acc_ce, dec.alu_op, ADDR_W'(dec.rf_a), N_SEL'(dec.rf_sel)};

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign accept        = bus.in_valid & bus.in_ready;
  // NOPs complete the handshake but never occupy a slot.
  assign push          = accept & ~is_nop;
  assign pop           = bus.out_valid & bus.out_ready;

  instr_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  // Controls read as zero whenever no entry is valid, so execute can use them ungated.
  assign bus.acc_ce = bus.out_valid & dout[EW-1];
  assign bus.alu_op = bus.out_valid ? dout[N_SEL+ADDR_W+2 -: 3]     : '0;
  assign bus.rf_a   = bus.out_valid ? dout[N_SEL+ADDR_W-1 -: ADDR_W] : '0;
  assign bus.rf_sel = bus.out_valid ? dout[N_SEL-1:0]                : '0;

`ifdef DECODE_STATS_EN
  logic        is_alu;
  logic        is_st;
  logic [15:0] cnt_alu;
  logic [15:0] cnt_st;
  logic [15:0] cnt_nop;

  assign is_alu = (opcode[2:0] != 3'b111);
  assign is_st  = (opcode == OP_ST);

  // Counted on acceptance, so words dropped by a concurrent flush still register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_alu <= '0;
      cnt_st  <= '0;
      cnt_nop <= '0;
    end else if (bus.clr_stats) begin
      cnt_alu <= '0;
      cnt_st  <= '0;
      cnt_nop <= '0;
    end else begin
      if (accept && is_alu && cnt_alu != 16'hFFFF) cnt_alu <= cnt_alu + 16'd1;
      if (accept && is_st  && cnt_st  != 16'hFFFF) cnt_st  <= cnt_st  + 16'd1;
      if (accept && is_nop && cnt_nop != 16'hFFFF) cnt_nop <= cnt_nop + 16'd1;
    end
  end

  assign bus.cnt_alu = cnt_alu;
  assign bus.cnt_st  = cnt_st;
  assign bus.cnt_nop = cnt_nop;
`endif

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed and random bench for instr_decode_pipe with an expected-entry scoreboard.
// Define DECODE_STATS_EN to also exercise the statistics counters.
module tb_instr_decode_pipe;

  localparam int ADDR_W = 2;
  localparam int W      = 1 + 3 + ADDR_W + (2**ADDR_W - 1);

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   exp_alu  = 0;
  int   exp_st   = 0;
  int   exp_nop  = 0;
  logic [W-1:0] exp_q[$];

  instr_decode_pipe_if #(.ADDR_W(ADDR_W)) bus ();

  instr_decode_pipe #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: {acc_ce, alu_op, rf_a, rf_sel}
  function automatic logic [W-1:0] model(input logic [5:0] w);
    logic [3:0] op;
    logic [1:0] a;
    logic [2:0] sel;
    op = w[5:2];
    a  = w[1:0];
    if (op[2:0] != 3'b111) return {1'b1, op[2:0], a, 3'b000};
    sel = 3'b000;
    if (a == 2'd0) sel = 3'b001;
    if (a == 2'd1) sel = 3'b010;
    if (a == 2'd2) sel = 3'b100;
    return {1'b0, 3'b000, 2'b00, sel};
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic count_class(input logic [5:0] w);
    if (w[4:2] != 3'b111) exp_alu++;
    else if (w[5:2] == 4'b0111) exp_st++;
    else exp_nop++;
  endtask

  // Called and returns at posedge+1; records the expected entry when the word is taken.
  task automatic send(input logic [5:0] w);
    bit done = 0;
    bus.data     = w;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        count_class(w);
        if (w[5:2] != 4'b1111) exp_q.push_back(model(w));
        done = 1;
      end else if (n >= 4) begin
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: a pop happens at the coming edge whenever valid & ready & !flush.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && bus.flush === 1'b0) begin
        if (exp_q.size() == 0) chk("unexpected_entry", {bus.acc_ce, bus.alu_op, bus.rf_a, bus.rf_sel}, 32'hDEAD);
        else chk("out_entry", {bus.acc_ce, bus.alu_op, bus.rf_a, bus.rf_sel}, exp_q.pop_front());
      end else if (bus.out_valid === 1'b0) begin
        chk("idle_gated", {bus.acc_ce, bus.alu_op, bus.rf_a, bus.rf_sel}, 32'd0);
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.data      = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
`ifdef DECODE_STATS_EN
    bus.clr_stats = 1'b0;
`endif
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill the queue, then reset asynchronously between edges
    send(6'b0000_00);
    send(6'b0001_01);
    @(negedge clk);
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_alu = 0; exp_st = 0; exp_nop = 0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_ctrls", {bus.acc_ce, bus.alu_op, bus.rf_a, bus.rf_sel}, 0);
`ifdef DECODE_STATS_EN
    chk("midrst_stats", {bus.cnt_alu, bus.cnt_st}, 0);
`endif
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU decodes, one-cycle latency
    bus.out_ready = 1'b1;
    send(6'b0001_01);
    @(negedge clk);
    chk("sub_out_valid", bus.out_valid, 1);
    chk("sub_alu_op", bus.alu_op, 3'b001);
    @(posedge clk); #1;
    send(6'b1010_00);
    @(negedge clk);
    chk("and_op3_ignored", bus.alu_op, 3'b010);
    @(posedge clk); #1;

    // Stores, including discarded store to RZ
    send(6'b0111_10);
    @(negedge clk);
    chk("st_r2_sel", {bus.acc_ce, bus.rf_sel}, 4'b0100);
    @(posedge clk); #1;
    send(6'b0111_11);
    @(negedge clk);
    chk("st_rz_valid", bus.out_valid, 1);
    chk("st_rz_sel", {bus.acc_ce, bus.rf_sel}, 4'b0000);
    @(posedge clk); #1;

    // NOP never enqueues
    send(6'b1111_00);
    @(negedge clk);
    chk("nop_out_valid", bus.out_valid, 0);
    chk("nop_in_ready", bus.in_ready, 1);
`ifdef DECODE_STATS_EN
    chk("nop_cnt", bus.cnt_nop, 1);
`endif
    @(posedge clk); #1;

    // Back-pressure
    bus.out_ready = 1'b0;
    send(6'b0000_00);
    send(6'b0001_01);
    bus.data     = 6'b0010_10;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(6'b0010_10);
    drain(20);

    // Flush with a full queue, offered word and pop
    bus.out_ready = 1'b0;
    send(6'b0010_01);
    send(6'b0011_10);
    bus.data      = 6'b0100_00;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("flush_full_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;

    // Flush with one entry while a word is actually accepted
    bus.out_ready = 1'b0;
    send(6'b0011_01);
    bus.data      = 6'b0100_10;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("flush_push_in_ready", bus.in_ready, 1);
    if (bus.in_ready === 1'b1) exp_alu++;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_push_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    send(6'b0101_11);
    drain(20);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      send(6'($urandom_range(0, 63)));
    end
    drain(20);

`ifdef DECODE_STATS_EN
    chk("stats_alu", bus.cnt_alu, sat(exp_alu));
    chk("stats_st", bus.cnt_st, sat(exp_st));
    chk("stats_nop", bus.cnt_nop, sat(exp_nop));
    // Saturation, with flush held so no entries reach the output
    bus.flush    = 1'b1;
    bus.data     = 6'b0000_01;
    bus.in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("stats_alu_sat", bus.cnt_alu, 16'hFFFF);
    bus.clr_stats = 1'b1;
    @(posedge clk); #1;
    bus.clr_stats = 1'b0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    @(negedge clk);
    chk("stats_clr_prio", bus.cnt_alu, 0);
    @(posedge clk); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
